// File: rtl/ptw_dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter between the core load/store path and the PTW.
// The memory command and size encodings are also used by the page-table walker.
package ptw_dmem_arb_pkg;

   localparam int unsigned CMD_W = 5;
   localparam int unsigned TYP_W = 4;

   // Memory commands
   localparam logic [CMD_W-1:0] M_XRD   = 5'b00000;
   localparam logic [CMD_W-1:0] M_XWR   = 5'b00001;
   localparam logic [CMD_W-1:0] M_XA_OR = 5'b01010;

   // Access sizes
   localparam logic [TYP_W-1:0] MT_D = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_CORE,
      BUSY_PTW
   } dmem_arb_state_t;

   typedef enum logic {
      OWN_CORE,
      OWN_PTW
   } dmem_arb_owner_t;

endpackage

// File: rtl/ptw_dmem_arb_if.sv
// Bundle of the core, PTW and dmem request/response signals around the arbiter.
// slave: the arbiter's view. master: the surrounding core/PTW/dmem environment.
interface ptw_dmem_arb_if
   import ptw_dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 40,
   parameter int unsigned DATA_W = 64
) ();

   // Core side
   logic              core_req_valid_i;
   logic              core_req_ready_o;
   logic [ADDR_W-1:0] core_req_addr_i;
   logic [CMD_W-1:0]  core_req_cmd_i;
   logic [TYP_W-1:0]  core_req_typ_i;
   logic [DATA_W-1:0] core_req_data_i;
   logic              core_resp_valid_o;
   logic              core_resp_nack_o;
   logic [DATA_W-1:0] core_resp_data_o;

   // PTW side
   logic              ptw_req_valid_i;
   logic              ptw_req_ready_o;
   logic [ADDR_W-1:0] ptw_req_addr_i;
   logic [CMD_W-1:0]  ptw_req_cmd_i;
   logic [TYP_W-1:0]  ptw_req_typ_i;
   logic [DATA_W-1:0] ptw_req_data_i;
   logic              ptw_resp_valid_o;
   logic              ptw_resp_nack_o;
   logic [DATA_W-1:0] ptw_resp_data_o;

   // Shared dmem port
   logic              dmem_req_valid_o;
   logic              dmem_ready_i;
   logic [ADDR_W-1:0] dmem_req_addr_o;
   logic [CMD_W-1:0]  dmem_req_cmd_o;
   logic [TYP_W-1:0]  dmem_req_typ_o;
   logic [DATA_W-1:0] dmem_req_data_o;
   logic              dmem_req_phys_o;
   logic              dmem_req_kill_o;
   logic              dmem_resp_valid_i;
   logic              dmem_resp_nack_i;
   logic [DATA_W-1:0] dmem_resp_data_i;

   // Performance events
   logic              pmu_ptw_stall_o;
   logic              pmu_timeout_o;

   modport slave (
      input  core_req_valid_i, core_req_addr_i, core_req_cmd_i, core_req_typ_i, core_req_data_i,
      output core_req_ready_o, core_resp_valid_o, core_resp_nack_o, core_resp_data_o,
      input  ptw_req_valid_i, ptw_req_addr_i, ptw_req_cmd_i, ptw_req_typ_i, ptw_req_data_i,
      output ptw_req_ready_o, ptw_resp_valid_o, ptw_resp_nack_o, ptw_resp_data_o,
      output dmem_req_valid_o, dmem_req_addr_o, dmem_req_cmd_o, dmem_req_typ_o,
      output dmem_req_data_o, dmem_req_phys_o, dmem_req_kill_o,
      input  dmem_ready_i, dmem_resp_valid_i, dmem_resp_nack_i, dmem_resp_data_i,
      output pmu_ptw_stall_o, pmu_timeout_o
   );

   modport master (
      output core_req_valid_i, core_req_addr_i, core_req_cmd_i, core_req_typ_i, core_req_data_i,
      input  core_req_ready_o, core_resp_valid_o, core_resp_nack_o, core_resp_data_o,
      output ptw_req_valid_i, ptw_req_addr_i, ptw_req_cmd_i, ptw_req_typ_i, ptw_req_data_i,
      input  ptw_req_ready_o, ptw_resp_valid_o, ptw_resp_nack_o, ptw_resp_data_o,
      input  dmem_req_valid_o, dmem_req_addr_o, dmem_req_cmd_o, dmem_req_typ_o,
      input  dmem_req_data_o, dmem_req_phys_o, dmem_req_kill_o,
      output dmem_ready_i, dmem_resp_valid_i, dmem_resp_nack_i, dmem_resp_data_i,
      input  pmu_ptw_stall_o, pmu_timeout_o
   );

endinterface

// File: rtl/ptw_dmem_arb.sv
// Arbiter sharing the single dmem port between the core load/store path and the PTW.
// One transaction in flight; core wins by default, an aging counter lets a waiting PTW in
// after STARVE_MAX core grants. Responses go to the owner recorded at acceptance, and a
// watchdog turns a lost response into a nack. STARVE_MAX must be at least 1.
module ptw_dmem_arb
   import ptw_dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 40,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic            clk_i,
   input logic            rstn_i,
   ptw_dmem_arb_if.slave  bus
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam logic [WDOG_W-1:0]   WDOG_LIM   = WDOG_W'(TIMEOUT);

   dmem_arb_state_t     state_q;
   dmem_arb_owner_t     owner_q;
   logic [STARVE_W-1:0] starve_q;
   logic [WDOG_W-1:0]   wdog_q;

   logic              in_idle;
   logic              in_busy;
   logic              sel_ptw;
   logic              grant_valid;
   logic              accept;
   logic              core_ready;
   logic              ptw_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [CMD_W-1:0]  req_cmd;
   logic [TYP_W-1:0]  req_typ;
   logic [DATA_W-1:0] req_data;

   logic              resp_evt;
   logic              timeout;
   logic              deliver;
   logic              nack;
   logic              end_txn;
   logic [DATA_W-1:0] resp_data;

   // Grant selection and payload mux; only meaningful while idle, re-evaluated every cycle.
   always_comb begin
      in_idle     = (state_q == IDLE);
      in_busy     = !in_idle;
      sel_ptw     = bus.ptw_req_valid_i && (!bus.core_req_valid_i || starve_q == STARVE_LIM);
      grant_valid = in_idle && (bus.core_req_valid_i || bus.ptw_req_valid_i);
      accept      = grant_valid && bus.dmem_ready_i;
      core_ready  = in_idle && bus.core_req_valid_i && !sel_ptw && bus.dmem_ready_i;
      ptw_ready   = in_idle && sel_ptw && bus.dmem_ready_i;
      req_addr    = '0;
      req_cmd     = '0;
      req_typ     = '0;
      req_data    = '0;
      if (grant_valid) begin
         if (sel_ptw) begin
            req_addr = bus.ptw_req_addr_i;
            req_cmd  = bus.ptw_req_cmd_i;
            req_typ  = bus.ptw_req_typ_i;
            req_data = bus.ptw_req_data_i;
         end else begin
            req_addr = bus.core_req_addr_i;
            req_cmd  = bus.core_req_cmd_i;
            req_typ  = bus.core_req_typ_i;
            req_data = bus.core_req_data_i;
         end
      end
   end

   // Response decode; dmem responses seen while idle are ignored entirely.
   always_comb begin
      resp_evt  = in_busy && (bus.dmem_resp_valid_i || bus.dmem_resp_nack_i);
      timeout   = in_busy && !resp_evt && (wdog_q == WDOG_LIM);
      // nack takes precedence over data when both arrive together
      deliver   = in_busy && bus.dmem_resp_valid_i && !bus.dmem_resp_nack_i;
      nack      = (in_busy && bus.dmem_resp_nack_i) || timeout;
      end_txn   = resp_evt || timeout;
      resp_data = deliver ? bus.dmem_resp_data_i : '0;
   end

   // Transaction FSM: record owner at acceptance, return to idle on any response or timeout.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         owner_q <= OWN_CORE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= sel_ptw ? BUSY_PTW : BUSY_CORE;
                  owner_q <= sel_ptw ? OWN_PTW : OWN_CORE;
               end
            end
            BUSY_CORE, BUSY_PTW: begin
               if (end_txn) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Watchdog: counts cycles spent waiting for the in-flight response.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wdog_q <= '0;
      end else if (accept) begin
         wdog_q <= '0;
      end else if (in_busy) begin
         wdog_q <= wdog_q + 1'b1;
      end
   end

   // Aging counter: core grants taken while the PTW is waiting, saturating at the limit.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         starve_q <= '0;
      end else if (!bus.ptw_req_valid_i) begin
         starve_q <= '0;
      end else if (accept && sel_ptw) begin
         starve_q <= '0;
      end else if (accept && starve_q != STARVE_LIM) begin
         starve_q <= starve_q + 1'b1;
      end
   end

   assign bus.core_req_ready_o  = core_ready;
   assign bus.ptw_req_ready_o   = ptw_ready;

   assign bus.dmem_req_valid_o  = grant_valid;
   assign bus.dmem_req_addr_o   = req_addr;
   assign bus.dmem_req_cmd_o    = req_cmd;
   assign bus.dmem_req_typ_o    = req_typ;
   assign bus.dmem_req_data_o   = req_data;
   assign bus.dmem_req_phys_o   = 1'b1;
   assign bus.dmem_req_kill_o   = 1'b0;

   assign bus.core_resp_valid_o = deliver && (owner_q == OWN_CORE);
   assign bus.core_resp_nack_o  = nack && (owner_q == OWN_CORE);
   assign bus.core_resp_data_o  = (owner_q == OWN_CORE) ? resp_data : '0;
   assign bus.ptw_resp_valid_o  = deliver && (owner_q == OWN_PTW);
   assign bus.ptw_resp_nack_o   = nack && (owner_q == OWN_PTW);
   assign bus.ptw_resp_data_o   = (owner_q == OWN_PTW) ? resp_data : '0;

   assign bus.pmu_ptw_stall_o   = bus.ptw_req_valid_i && !ptw_ready;
   assign bus.pmu_timeout_o     = timeout;

endmodule

// File: tb/tb_ptw_dmem_arb.sv
// Bench for ptw_dmem_arb: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_ptw_dmem_arb;
   import ptw_dmem_arb_pkg::*;

   localparam int unsigned ADDR_W     = 40;
   localparam int unsigned DATA_W     = 64;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned TIMEOUT    = 255;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ptw_dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ptw_dmem_arb #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: whether a transaction is outstanding, who owns it, how many core
   // grants the PTW has watched go by, and how long the outstanding one has waited.
   bit m_busy;
   bit m_own_ptw;
   int m_streak;
   int m_wait;
   bit m_ptw_win;
   bit m_core_win;
   bit m_end;

   bit              e_dreq_v, e_core_rdy, e_ptw_rdy, e_core_rv, e_core_nk, e_ptw_rv, e_ptw_nk;
   bit              e_stall, e_tmo;
   logic [39:0]     e_addr;
   logic [4:0]      e_cmd;
   logic [3:0]      e_typ;
   logic [63:0]     e_wdata, e_core_rd, e_ptw_rd;

   function automatic logic [10:0] dut_flags();
      return {bus.dmem_req_valid_o, bus.core_req_ready_o, bus.ptw_req_ready_o,
              bus.core_resp_valid_o, bus.core_resp_nack_o, bus.ptw_resp_valid_o,
              bus.ptw_resp_nack_o, bus.pmu_ptw_stall_o, bus.pmu_timeout_o,
              bus.dmem_req_phys_o, bus.dmem_req_kill_o};
   endfunction

   function automatic logic [10:0] exp_flags();
      return {e_dreq_v, e_core_rdy, e_ptw_rdy, e_core_rv, e_core_nk, e_ptw_rv, e_ptw_nk,
              e_stall, e_tmo, 1'b1, 1'b0};
   endfunction

   function automatic void model_eval();
      bit got_nack, got_data, expired;
      {e_dreq_v, e_core_rdy, e_ptw_rdy, e_core_rv, e_core_nk, e_ptw_rv, e_ptw_nk} = '0;
      e_tmo = 0; e_addr = '0; e_cmd = '0; e_typ = '0; e_wdata = '0;
      e_core_rd = '0; e_ptw_rd = '0; m_ptw_win = 0; m_core_win = 0; m_end = 0;
      if (!m_busy) begin
         m_ptw_win  = bus.ptw_req_valid_i && (!bus.core_req_valid_i || m_streak >= STARVE_MAX);
         m_core_win = bus.core_req_valid_i && !m_ptw_win;
         e_dreq_v   = m_ptw_win || m_core_win;
         e_core_rdy = m_core_win && bus.dmem_ready_i;
         e_ptw_rdy  = m_ptw_win && bus.dmem_ready_i;
         if (m_ptw_win) begin
            e_addr = bus.ptw_req_addr_i; e_cmd = bus.ptw_req_cmd_i;
            e_typ = bus.ptw_req_typ_i; e_wdata = bus.ptw_req_data_i;
         end else if (m_core_win) begin
            e_addr = bus.core_req_addr_i; e_cmd = bus.core_req_cmd_i;
            e_typ = bus.core_req_typ_i; e_wdata = bus.core_req_data_i;
         end
      end else begin
         got_nack = bus.dmem_resp_nack_i;
         got_data = bus.dmem_resp_valid_i && !bus.dmem_resp_nack_i;
         expired  = !bus.dmem_resp_valid_i && !bus.dmem_resp_nack_i && (m_wait == TIMEOUT);
         m_end    = got_nack || got_data || expired;
         e_tmo    = expired;
         if (m_own_ptw) begin
            e_ptw_nk = got_nack || expired;
            e_ptw_rv = got_data;
            e_ptw_rd = got_data ? bus.dmem_resp_data_i : 64'h0;
         end else begin
            e_core_nk = got_nack || expired;
            e_core_rv = got_data;
            e_core_rd = got_data ? bus.dmem_resp_data_i : 64'h0;
         end
      end
      e_stall = bus.ptw_req_valid_i && !e_ptw_rdy;
   endfunction

   function automatic void model_commit();
      if (!rstn) begin
         m_busy = 0; m_own_ptw = 0; m_streak = 0; m_wait = 0;
         return;
      end
      if (!m_busy) begin
         if ((m_ptw_win || m_core_win) && bus.dmem_ready_i) begin
            m_busy = 1; m_own_ptw = m_ptw_win; m_wait = 0;
            if (m_ptw_win) m_streak = 0;
            else if (bus.ptw_req_valid_i && m_streak < STARVE_MAX) m_streak++;
         end
      end else if (m_end) begin
         m_busy = 0;
      end else begin
         m_wait++;
      end
      if (!bus.ptw_req_valid_i) m_streak = 0;
   endfunction

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_eval();
      model_commit();
      #1;
   endtask

   task automatic clear_inputs();
      bus.core_req_valid_i = 0; bus.core_req_addr_i = '0; bus.core_req_cmd_i = '0;
      bus.core_req_typ_i = '0; bus.core_req_data_i = '0;
      bus.ptw_req_valid_i = 0; bus.ptw_req_addr_i = '0; bus.ptw_req_cmd_i = '0;
      bus.ptw_req_typ_i = '0; bus.ptw_req_data_i = '0;
      bus.dmem_ready_i = 0; bus.dmem_resp_valid_i = 0; bus.dmem_resp_nack_i = 0;
      bus.dmem_resp_data_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rstn = 0;
      tick();
      tick();
      rstn = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn = 0;
      tick();
      settle();
      checks++;
      if (dut_flags() !== 11'b000_0000_0010)
         $display("FAIL reset_flags: got %b expected %b", dut_flags(), 11'b000_0000_0010);
      checks++;
      if ({bus.dmem_req_addr_o, bus.core_resp_data_o, bus.ptw_resp_data_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: got addr %h core %h ptw %h expected 0",
                  bus.dmem_req_addr_o, bus.core_resp_data_o, bus.ptw_resp_data_o);
      end
      if (dut_flags() !== 11'b000_0000_0010) failures++;
      tick();
      rstn = 1;
      settle();
      checks++;
      if (dut_flags() !== 11'b000_0000_0010) begin
         failures++;
         $display("FAIL post_reset_flags: got %b expected %b", dut_flags(), 11'b000_0000_0010);
      end
      tick();
   endtask

   task automatic test_core_read();
      do_reset();
      bus.core_req_valid_i = 1; bus.core_req_addr_i = 40'h80_0000_1000;
      bus.core_req_cmd_i = M_XRD; bus.core_req_typ_i = MT_D; bus.dmem_ready_i = 1;
      settle();
      checks++;
      if (bus.dmem_req_valid_o !== 1'b1 || bus.core_req_ready_o !== 1'b1 ||
          bus.dmem_req_addr_o !== 40'h80_0000_1000 || bus.dmem_req_cmd_o !== M_XRD) begin
         failures++;
         $display("FAIL core_read_req: got v=%b rdy=%b addr=%h cmd=%h expected 1 1 %h %h",
                  bus.dmem_req_valid_o, bus.core_req_ready_o, bus.dmem_req_addr_o,
                  bus.dmem_req_cmd_o, 40'h80_0000_1000, M_XRD);
      end
      tick();
      bus.core_req_valid_i = 0;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++;
         if ({bus.core_resp_valid_o, bus.ptw_resp_valid_o, bus.dmem_req_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL core_read_wait: got %b expected 000",
                     {bus.core_resp_valid_o, bus.ptw_resp_valid_o, bus.dmem_req_valid_o});
         end
         tick();
      end
      bus.dmem_resp_valid_i = 1; bus.dmem_resp_data_i = 64'hDEAD_BEEF;
      bus.core_req_valid_i = 1;
      settle();
      checks++;
      if (bus.core_resp_valid_o !== 1'b1 || bus.core_resp_data_o !== 64'hDEAD_BEEF) begin
         failures++;
         $display("FAIL core_read_resp: got v=%b data=%h expected 1 deadbeef",
                  bus.core_resp_valid_o, bus.core_resp_data_o);
      end
      checks++;
      if ({bus.ptw_resp_valid_o, bus.ptw_resp_nack_o, bus.ptw_resp_data_o} !== '0) begin
         failures++;
         $display("FAIL core_read_ptw_quiet: got v=%b n=%b d=%h expected 0",
                  bus.ptw_resp_valid_o, bus.ptw_resp_nack_o, bus.ptw_resp_data_o);
      end
      checks++;
      if (bus.dmem_req_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL core_read_bubble: got %b expected 0", bus.dmem_req_valid_o);
      end
      tick();
      bus.dmem_resp_valid_i = 0; bus.dmem_resp_data_i = '0; bus.dmem_ready_i = 0;
      settle();
      checks++;
      if (bus.dmem_req_valid_o !== 1'b1 || bus.core_resp_valid_o !== 1'b0 ||
          bus.core_resp_data_o !== 64'h0) begin
         failures++;
         $display("FAIL core_read_idle: got req=%b v=%b d=%h expected 1 0 0",
                  bus.dmem_req_valid_o, bus.core_resp_valid_o, bus.core_resp_data_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_aging();
      bit exp_p;
      do_reset();
      bus.core_req_valid_i = 1; bus.core_req_addr_i = 40'h1000;
      bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h2000; bus.dmem_ready_i = 1;
      for (int i = 0; i < 10; i++) begin
         exp_p = (i % 5 == 4);
         bus.dmem_resp_valid_i = 0;
         settle();
         checks++;
         if ({bus.core_req_ready_o, bus.ptw_req_ready_o} !== (exp_p ? 2'b01 : 2'b10) ||
             bus.dmem_req_addr_o !== (exp_p ? 40'h2000 : 40'h1000)) begin
            failures++;
            $display("FAIL aging_grant[%0d]: got rdy=%b addr=%h expected ptw=%b", i,
                     {bus.core_req_ready_o, bus.ptw_req_ready_o}, bus.dmem_req_addr_o, exp_p);
         end
         checks++;
         if (bus.pmu_ptw_stall_o !== !exp_p) begin
            failures++;
            $display("FAIL aging_stall_idle[%0d]: got %b expected %b", i,
                     bus.pmu_ptw_stall_o, !exp_p);
         end
         tick();
         bus.dmem_resp_valid_i = 1; bus.dmem_resp_data_i = 64'(i + 1);
         settle();
         checks++;
         if ({bus.core_resp_valid_o, bus.ptw_resp_valid_o, bus.pmu_ptw_stall_o} !==
             (exp_p ? 3'b011 : 3'b101)) begin
            failures++;
            $display("FAIL aging_route[%0d]: got %b expected ptw=%b", i,
                     {bus.core_resp_valid_o, bus.ptw_resp_valid_o, bus.pmu_ptw_stall_o}, exp_p);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_ptw_nack();
      do_reset();
      bus.ptw_req_valid_i = 1; bus.ptw_req_addr_i = 40'h3000; bus.dmem_ready_i = 1;
      settle();
      checks++;
      if (bus.ptw_req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ptw_nack_accept: got %b expected 1", bus.ptw_req_ready_o);
      end
      tick();
      bus.dmem_resp_nack_i = 1;
      settle();
      checks++;
      if ({bus.ptw_resp_nack_o, bus.ptw_resp_valid_o, bus.core_resp_nack_o} !== 3'b100) begin
         failures++;
         $display("FAIL ptw_nack_route: got %b expected 100",
                  {bus.ptw_resp_nack_o, bus.ptw_resp_valid_o, bus.core_resp_nack_o});
      end
      tick();
      bus.dmem_resp_nack_i = 0;
      settle();
      checks++;
      if ({bus.ptw_req_ready_o, bus.dmem_req_valid_o, bus.ptw_resp_nack_o} !== 3'b110) begin
         failures++;
         $display("FAIL ptw_nack_regrant: got %b expected 110",
                  {bus.ptw_req_ready_o, bus.dmem_req_valid_o, bus.ptw_resp_nack_o});
      end
      tick();
      bus.ptw_req_valid_i = 0;
      bus.dmem_resp_valid_i = 1;
      tick();
      clear_inputs();
   endtask

   task automatic test_timeout();
      bit bad;
      do_reset();
      bus.core_req_valid_i = 1; bus.dmem_ready_i = 1;
      tick();
      bus.core_req_valid_i = 0;
      bad = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         settle();
         if (bus.core_resp_nack_o !== 1'b0 || bus.pmu_timeout_o !== 1'b0) bad = 1;
         tick();
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL timeout_early: got an early nack/timeout expected none");
      end
      settle();
      checks++;
      if ({bus.core_resp_nack_o, bus.pmu_timeout_o, bus.core_resp_valid_o} !== 3'b110) begin
         failures++;
         $display("FAIL timeout_pulse: got %b expected 110",
                  {bus.core_resp_nack_o, bus.pmu_timeout_o, bus.core_resp_valid_o});
      end
      tick();
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         bus.dmem_resp_valid_i = (i == 5);
         bus.dmem_resp_data_i  = 64'h1234;
         settle();
         if ({bus.core_resp_valid_o, bus.core_resp_nack_o, bus.pmu_timeout_o,
              bus.core_resp_data_o} !== '0) bad = 1;
         tick();
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL timeout_late_resp: got response outputs active expected discard");
      end
      clear_inputs();
   endtask

   task automatic test_nack_wins();
      do_reset();
      bus.ptw_req_valid_i = 1; bus.dmem_ready_i = 1;
      tick();
      bus.ptw_req_valid_i = 0;
      bus.dmem_resp_valid_i = 1; bus.dmem_resp_nack_i = 1; bus.dmem_resp_data_i = 64'h55;
      settle();
      checks++;
      if ({bus.ptw_resp_nack_o, bus.ptw_resp_valid_o} !== 2'b10 ||
          bus.ptw_resp_data_o !== 64'h0) begin
         failures++;
         $display("FAIL nack_wins: got n=%b v=%b d=%h expected 1 0 0",
                  bus.ptw_resp_nack_o, bus.ptw_resp_valid_o, bus.ptw_resp_data_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ptw_req_valid_i = 1; bus.dmem_ready_i = 1;
      tick();
      bus.ptw_req_valid_i = 0;
      rstn = 0;
      tick();
      rstn = 1;
      bus.dmem_resp_valid_i = 1; bus.dmem_resp_data_i = 64'hABCD;
      bus.ptw_req_valid_i = 1; bus.dmem_ready_i = 0;
      settle();
      checks++;
      if ({bus.ptw_resp_valid_o, bus.ptw_resp_nack_o, bus.core_resp_valid_o,
           bus.core_resp_nack_o} !== 4'b0000 || bus.dmem_req_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: got resp=%b req=%b expected 0000 1",
                  {bus.ptw_resp_valid_o, bus.ptw_resp_nack_o, bus.core_resp_valid_o,
                   bus.core_resp_nack_o}, bus.dmem_req_valid_o);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      logic [4:0] cmds [3];
      cmds[0] = M_XRD; cmds[1] = M_XWR; cmds[2] = M_XA_OR;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rstn                  = ($urandom_range(0, 199) != 0);
         bus.core_req_valid_i  = ($urandom_range(0, 2) != 0);
         bus.core_req_addr_i   = 40'({$urandom(), $urandom()});
         bus.core_req_cmd_i    = cmds[$urandom_range(0, 2)];
         bus.core_req_typ_i    = 4'($urandom());
         bus.core_req_data_i   = {$urandom(), $urandom()};
         bus.ptw_req_valid_i   = ($urandom_range(0, 2) != 0);
         bus.ptw_req_addr_i    = 40'({$urandom(), $urandom()});
         bus.ptw_req_cmd_i     = M_XRD;
         bus.ptw_req_typ_i     = MT_D;
         bus.ptw_req_data_i    = {$urandom(), $urandom()};
         bus.dmem_ready_i      = ($urandom_range(0, 3) != 0);
         bus.dmem_resp_valid_i = ($urandom_range(0, 3) == 0);
         bus.dmem_resp_nack_i  = ($urandom_range(0, 9) == 0);
         bus.dmem_resp_data_i  = {$urandom(), $urandom()};
         settle();
         checks++;
         if (dut_flags() !== exp_flags()) begin
            failures++;
            $display("FAIL rand_flags[%0d]: got %b expected %b", i, dut_flags(), exp_flags());
         end
         checks++;
         if ({bus.dmem_req_addr_o, bus.dmem_req_cmd_o, bus.dmem_req_typ_o, bus.dmem_req_data_o}
             !== {e_addr, e_cmd, e_typ, e_wdata}) begin
            failures++;
            $display("FAIL rand_payload[%0d]: got %h/%h/%h/%h expected %h/%h/%h/%h", i,
                     bus.dmem_req_addr_o, bus.dmem_req_cmd_o, bus.dmem_req_typ_o,
                     bus.dmem_req_data_o, e_addr, e_cmd, e_typ, e_wdata);
         end
         checks++;
         if ({bus.core_resp_data_o, bus.ptw_resp_data_o} !== {e_core_rd, e_ptw_rd}) begin
            failures++;
            $display("FAIL rand_resp_data[%0d]: got %h/%h expected %h/%h", i,
                     bus.core_resp_data_o, bus.ptw_resp_data_o, e_core_rd, e_ptw_rd);
         end
         tick();
      end
      rstn = 1;
      clear_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish within the time limit");
      $fatal(1, "time limit expired");
   end

   initial begin
      clear_inputs();
      m_busy = 0; m_own_ptw = 0; m_streak = 0; m_wait = 0;
      test_reset();
      test_core_read();
      test_aging();
      test_ptw_nack();
      test_timeout();
      test_nack_wins();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
